// File: rtl/kbd_pkg.sv
// Shared definitions for the keyboard port controller.
//   - Default I/O port addresses for the data and status/command ports.
//   - PS/2 set-2 prefix bytes (break and extended).
//   - set2_to_set1(): set-2 make code to set-1 make code translation.
//     Codes missing from the table pass through unchanged.
package kbd_pkg;

    localparam logic [15:0] KBD_DATA_PORT = 16'h0060;
    localparam logic [15:0] KBD_STAT_PORT = 16'h0064;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    function automatic logic [7:0] set2_to_set1(input logic [7:0] sc);
        logic [7:0] xt;
        case (sc)
            8'h01: xt = 8'h43;  8'h03: xt = 8'h3F;  8'h04: xt = 8'h3D;  8'h05: xt = 8'h3B;
            8'h06: xt = 8'h3C;  8'h07: xt = 8'h58;  8'h09: xt = 8'h44;  8'h0A: xt = 8'h42;
            8'h0B: xt = 8'h40;  8'h0C: xt = 8'h3E;  8'h0D: xt = 8'h0F;  8'h0E: xt = 8'h29;
            8'h11: xt = 8'h38;  8'h12: xt = 8'h2A;  8'h14: xt = 8'h1D;  8'h15: xt = 8'h10;
            8'h16: xt = 8'h02;  8'h1A: xt = 8'h2C;  8'h1B: xt = 8'h1F;  8'h1C: xt = 8'h1E;
            8'h1D: xt = 8'h11;  8'h1E: xt = 8'h03;  8'h21: xt = 8'h2E;  8'h22: xt = 8'h2D;
            8'h23: xt = 8'h20;  8'h24: xt = 8'h12;  8'h25: xt = 8'h05;  8'h26: xt = 8'h04;
            8'h29: xt = 8'h39;  8'h2A: xt = 8'h2F;  8'h2B: xt = 8'h21;  8'h2C: xt = 8'h14;
            8'h2D: xt = 8'h13;  8'h2E: xt = 8'h06;  8'h31: xt = 8'h31;  8'h32: xt = 8'h30;
            8'h33: xt = 8'h23;  8'h34: xt = 8'h22;  8'h35: xt = 8'h15;  8'h36: xt = 8'h07;
            8'h3A: xt = 8'h32;  8'h3B: xt = 8'h24;  8'h3C: xt = 8'h16;  8'h3D: xt = 8'h08;
            8'h3E: xt = 8'h09;  8'h41: xt = 8'h33;  8'h42: xt = 8'h25;  8'h43: xt = 8'h17;
            8'h44: xt = 8'h18;  8'h45: xt = 8'h0B;  8'h46: xt = 8'h0A;  8'h49: xt = 8'h34;
            8'h4A: xt = 8'h35;  8'h4B: xt = 8'h26;  8'h4C: xt = 8'h27;  8'h4D: xt = 8'h19;
            8'h4E: xt = 8'h0C;  8'h52: xt = 8'h28;  8'h54: xt = 8'h1A;  8'h55: xt = 8'h0D;
            8'h58: xt = 8'h3A;  8'h59: xt = 8'h36;  8'h5A: xt = 8'h1C;  8'h5B: xt = 8'h1B;
            8'h5D: xt = 8'h2B;  8'h66: xt = 8'h0E;  8'h69: xt = 8'h4F;  8'h6B: xt = 8'h4B;
            8'h6C: xt = 8'h47;  8'h70: xt = 8'h52;  8'h71: xt = 8'h53;  8'h72: xt = 8'h50;
            8'h73: xt = 8'h4C;  8'h74: xt = 8'h4D;  8'h75: xt = 8'h48;  8'h76: xt = 8'h01;
            8'h77: xt = 8'h45;  8'h78: xt = 8'h57;  8'h79: xt = 8'h4E;  8'h7A: xt = 8'h51;
            8'h7B: xt = 8'h4A;  8'h7C: xt = 8'h37;  8'h7D: xt = 8'h49;  8'h7E: xt = 8'h46;
            8'h83: xt = 8'h41;
            default: xt = sc;
        endcase
        return xt;
    endfunction

endpackage

// File: rtl/kbd_port_controller_if.sv
// CPU I/O port bus plus PS/2 byte feed and IRQ line of the keyboard controller.
//   port_addr    : I/O address
//   port_in      : read data returned to the CPU
//   port_out     : write data from the CPU
//   port_bit     : access width (0=byte, 1=word)
//   port_clk     : one-cycle write strobe
//   port_read    : read strobe, read completes on its falling edge
//   ps2_data     : received PS/2 set-2 byte
//   ps2_data_clk : one-cycle strobe, ps2_data valid
//   irq          : level interrupt request
// master = CPU/PS2 side, slave = controller.
interface kbd_port_controller_if;

    logic [15:0] port_addr;
    logic [15:0] port_in;
    logic [15:0] port_out;
    logic        port_bit;
    logic        port_clk;
    logic        port_read;
    logic [7:0]  ps2_data;
    logic        ps2_data_clk;
    logic        irq;

    modport master (
        output port_addr, port_out, port_bit, port_clk, port_read, ps2_data, ps2_data_clk,
        input  port_in, irq
    );

    modport slave (
        input  port_addr, port_out, port_bit, port_clk, port_read, ps2_data, ps2_data_clk,
        output port_in, irq
    );

endinterface

// File: rtl/kbd_fifo.sv
// Synchronous FIFO with show-ahead head output.
//   clk, rst_n : clock, synchronous active-low reset
//   push, din  : write request and data (ignored when full unless popping too)
//   pop        : read request (ignored when empty)
//   flush      : empties the FIFO, overrides push and pop
//   dout       : current head entry (undefined when empty)
//   empty, full, count : occupancy
module kbd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             pop_ok;
    logic             push_ok;

    assign empty  = (count_reg == '0);
    assign full   = (count_reg == CW'(DEPTH));
    assign count  = count_reg;
    // Head is read combinationally so a pushed entry is visible the next cycle.
    assign dout   = mem[rd_ptr_reg];

    assign pop_ok  = pop & ~empty;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign push_ok = push & (~full | pop_ok);

    // Pointers are exactly AW bits, so wrap modulo DEPTH is implicit.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/kbd_port_controller.sv
// PS/2 keyboard port controller: translates set-2 scancodes to set-1, queues
// them in a FIFO and exposes data/status ports to the CPU with a level IRQ.
//   clock50 : system clock (rising edge)
//   rst_n   : synchronous active-low reset
//   bus     : CPU port bus, PS/2 byte feed and irq (slave modport)
// Status byte: bit0 not empty, bit1 overflow, bit2 irq_en, bit3 full.
module kbd_port_controller
    import kbd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [15:0] DATA_PORT  = KBD_DATA_PORT,
    parameter logic [15:0] STAT_PORT  = KBD_STAT_PORT
)(
    input  logic                  clock50,
    input  logic                  rst_n,
    kbd_port_controller_if.slave  bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          read_prev_reg;
    logic          brk_reg,      brk_next;
    logic          overflow_reg, overflow_next;
    logic          irq_en_reg,   irq_en_next;
    logic          irq_reg;

    logic          data_sel, stat_sel;
    logic          read_done;
    logic          pop_req, pop_ok;
    logic          cmd_wr, flush;
    logic          push_req;
    logic [7:0]    push_byte;
    logic [7:0]    xt;
    logic [7:0]    head;
    logic [7:0]    status;
    logic          fifo_empty, fifo_full;
    logic [CW-1:0] fifo_count;
    logic [CW+14:0] unused_bits;

    assign unused_bits = {bus.port_bit, bus.port_out[15:2], fifo_count};

    assign data_sel  = (bus.port_addr == DATA_PORT);
    assign stat_sel  = (bus.port_addr == STAT_PORT);
    assign read_done = read_prev_reg & ~bus.port_read;
    assign pop_req   = read_done & data_sel;
    assign pop_ok    = pop_req & ~fifo_empty;
    assign cmd_wr    = bus.port_clk & stat_sel;
    assign flush     = cmd_wr & bus.port_out[0];
    assign xt        = set2_to_set1(bus.ps2_data);

    kbd_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clock50),
        .rst_n (rst_n),
        .push  (push_req),
        .pop   (pop_req),
        .flush (flush),
        .din   (push_byte),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // Scancode decode: F0 arms the break flag, E0 passes through untouched,
    // everything else is translated and consumes the break flag.
    always_comb begin
        push_req  = 1'b0;
        push_byte = 8'h00;
        brk_next  = brk_reg;
        if (bus.ps2_data_clk) begin
            if (bus.ps2_data == SC_BREAK) begin
                brk_next = 1'b1;
            end else if (bus.ps2_data == SC_EXT) begin
                push_req  = 1'b1;
                push_byte = SC_EXT;
            end else begin
                push_req  = 1'b1;
                push_byte = brk_reg ? {1'b1, xt[6:0]} : xt;
                brk_next  = 1'b0;
            end
        end
    end

    // A byte is lost only when full with no pop making room and no flush.
    // A new loss outranks a status read clearing the flag in the same cycle.
    always_comb begin
        overflow_next = overflow_reg;
        if (push_req && fifo_full && !pop_ok && !flush) begin
            overflow_next = 1'b1;
        end else if (read_done && stat_sel) begin
            overflow_next = 1'b0;
        end
    end

    always_comb begin
        irq_en_next = irq_en_reg;
        if (cmd_wr) irq_en_next = bus.port_out[1];
    end

    always_ff @(posedge clock50) begin
        if (!rst_n) begin
            read_prev_reg <= 1'b0;
            brk_reg       <= 1'b0;
            overflow_reg  <= 1'b0;
            irq_en_reg    <= 1'b1;
            irq_reg       <= 1'b0;
        end else begin
            read_prev_reg <= bus.port_read;
            brk_reg       <= brk_next;
            overflow_reg  <= overflow_next;
            irq_en_reg    <= irq_en_next;
            irq_reg       <= irq_en_reg & ~fifo_empty;
        end
    end

    assign status = {4'h0, fifo_full, irq_en_reg, overflow_reg, ~fifo_empty};

    always_comb begin
        bus.port_in = 16'h0000;
        if (data_sel) begin
            bus.port_in = {8'h00, (fifo_empty ? 8'h00 : head)};
        end else if (stat_sel) begin
            bus.port_in = {8'h00, status};
        end
    end

    assign bus.irq = irq_reg;

endmodule

// File: tb/tb_kbd_port_controller.sv
// Randomised self-checking bench for kbd_port_controller with a queue-based
// reference model and a set of hand-computed directed checks.
module tb_kbd_port_controller;

    localparam int DEPTH = 16;

    logic clock50 = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clock50 = ~clock50;

    kbd_port_controller_if bus();

    kbd_port_controller #(
        .FIFO_DEPTH (DEPTH),
        .DATA_PORT  (16'h0060),
        .STAT_PORT  (16'h0064)
    ) dut (
        .clock50 (clock50),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    // ---------------- reference model ----------------
    logic [7:0] xt_tab [256];
    logic [7:0] m_q [$];
    bit m_brk, m_ovf, m_irq_en, m_irq, m_rdp;
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    task automatic init_tab();
        for (int i = 0; i < 256; i++) xt_tab[i] = 8'(i);
        xt_tab['h01]='h43; xt_tab['h03]='h3F; xt_tab['h04]='h3D; xt_tab['h05]='h3B; xt_tab['h06]='h3C;
        xt_tab['h07]='h58; xt_tab['h09]='h44; xt_tab['h0A]='h42; xt_tab['h0B]='h40; xt_tab['h0C]='h3E;
        xt_tab['h0D]='h0F; xt_tab['h0E]='h29; xt_tab['h11]='h38; xt_tab['h12]='h2A; xt_tab['h14]='h1D;
        xt_tab['h15]='h10; xt_tab['h16]='h02; xt_tab['h1A]='h2C; xt_tab['h1B]='h1F; xt_tab['h1C]='h1E;
        xt_tab['h1D]='h11; xt_tab['h1E]='h03; xt_tab['h21]='h2E; xt_tab['h22]='h2D; xt_tab['h23]='h20;
        xt_tab['h24]='h12; xt_tab['h25]='h05; xt_tab['h26]='h04; xt_tab['h29]='h39; xt_tab['h2A]='h2F;
        xt_tab['h2B]='h21; xt_tab['h2C]='h14; xt_tab['h2D]='h13; xt_tab['h2E]='h06; xt_tab['h31]='h31;
        xt_tab['h32]='h30; xt_tab['h33]='h23; xt_tab['h34]='h22; xt_tab['h35]='h15; xt_tab['h36]='h07;
        xt_tab['h3A]='h32; xt_tab['h3B]='h24; xt_tab['h3C]='h16; xt_tab['h3D]='h08; xt_tab['h3E]='h09;
        xt_tab['h41]='h33; xt_tab['h42]='h25; xt_tab['h43]='h17; xt_tab['h44]='h18; xt_tab['h45]='h0B;
        xt_tab['h46]='h0A; xt_tab['h49]='h34; xt_tab['h4A]='h35; xt_tab['h4B]='h26; xt_tab['h4C]='h27;
        xt_tab['h4D]='h19; xt_tab['h4E]='h0C; xt_tab['h52]='h28; xt_tab['h54]='h1A; xt_tab['h55]='h0D;
        xt_tab['h58]='h3A; xt_tab['h59]='h36; xt_tab['h5A]='h1C; xt_tab['h5B]='h1B; xt_tab['h5D]='h2B;
        xt_tab['h66]='h0E; xt_tab['h69]='h4F; xt_tab['h6B]='h4B; xt_tab['h6C]='h47; xt_tab['h70]='h52;
        xt_tab['h71]='h53; xt_tab['h72]='h50; xt_tab['h73]='h4C; xt_tab['h74]='h4D; xt_tab['h75]='h48;
        xt_tab['h76]='h01; xt_tab['h77]='h45; xt_tab['h78]='h57; xt_tab['h79]='h4E; xt_tab['h7A]='h51;
        xt_tab['h7B]='h4A; xt_tab['h7C]='h37; xt_tab['h7D]='h49; xt_tab['h7E]='h46; xt_tab['h83]='h41;
    endtask

    // One clock edge of the controller's behaviour, from the current inputs.
    task automatic model_step();
        bit rd_done, do_pop, do_flush, want_push, stat_rd;
        logic [7:0] b;
        if (!rst_n) begin
            m_q.delete();
            m_brk = 0; m_ovf = 0; m_irq_en = 1; m_irq = 0; m_rdp = 0;
            return;
        end
        m_irq    = m_irq_en && (m_q.size() > 0);
        rd_done  = m_rdp && !bus.port_read;
        m_rdp    = bus.port_read;
        do_pop   = rd_done && bus.port_addr == 16'h0060 && m_q.size() > 0;
        stat_rd  = rd_done && bus.port_addr == 16'h0064;
        do_flush = bus.port_clk && bus.port_addr == 16'h0064 && bus.port_out[0];
        want_push = 0;
        b = 8'h00;
        if (bus.ps2_data_clk) begin
            if (bus.ps2_data == 8'hF0) m_brk = 1;
            else if (bus.ps2_data == 8'hE0) begin want_push = 1; b = 8'hE0; end
            else begin
                want_push = 1;
                b = xt_tab[bus.ps2_data];
                if (m_brk) b = b | 8'h80;
                m_brk = 0;
            end
        end
        if (do_flush) begin
            m_q.delete();
            if (stat_rd) m_ovf = 0;
        end else begin
            if (want_push && m_q.size() == DEPTH && !do_pop) m_ovf = 1;
            else if (stat_rd) m_ovf = 0;
            if (do_pop) void'(m_q.pop_front());
            if (want_push && m_q.size() < DEPTH) m_q.push_back(b);
        end
        if (bus.port_clk && bus.port_addr == 16'h0064) m_irq_en = bus.port_out[1];
    endtask

    function automatic logic [15:0] model_port_in(input logic [15:0] a);
        if (a == 16'h0060) return (m_q.size() > 0) ? {8'h00, m_q[0]} : 16'h0000;
        if (a == 16'h0064)
            return {12'h000, (m_q.size() == DEPTH), m_irq_en, m_ovf, (m_q.size() > 0)};
        return 16'h0000;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock50);
        model_step();
        #1;
        cyc++;
        chk("port_in", bus.port_in, model_port_in(bus.port_addr));
        chk("irq", {15'h0, bus.irq}, {15'h0, m_irq});
    endtask

    task automatic peek(input logic [15:0] a, output logic [15:0] v);
        bus.port_addr = a;
        #1;
        v = bus.port_in;
    endtask

    task automatic push(input logic [7:0] b);
        bus.ps2_data = b;
        bus.ps2_data_clk = 1'b1;
        step();
        bus.ps2_data_clk = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a);
        bus.port_addr = a;
        bus.port_read = 1'b1;
        step();
        bus.port_read = 1'b0;
        step();
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus.port_addr = a;
        bus.port_out = d;
        bus.port_clk = 1'b1;
        step();
        bus.port_clk = 1'b0;
    endtask

    initial begin
        logic [15:0] v;
        init_tab();
        m_brk = 0; m_ovf = 0; m_irq_en = 1; m_irq = 0; m_rdp = 0;
        bus.port_addr = 16'h0060; bus.port_out = 16'h0000; bus.port_bit = 1'b0;
        bus.port_clk = 1'b0; bus.port_read = 1'b0; bus.ps2_data = 8'h00; bus.ps2_data_clk = 1'b0;

        // reset state
        rst_n = 1'b0;
        step(); step();
        peek(16'h0060, v); chk("rst_data", v, 16'h0000);
        peek(16'h0064, v); chk("rst_stat", v, 16'h0004);
        chk("rst_irq", {15'h0, bus.irq}, 16'h0000);
        rst_n = 1'b1;
        step();

        // single key, read pops it
        push(8'h76);
        peek(16'h0060, v); chk("esc_head", v, 16'h0001);
        peek(16'h0064, v); chk("esc_stat", v, 16'h0005);
        rd(16'h0060);
        peek(16'h0064, v); chk("esc_popped", v, 16'h0004);
        step();

        // break + extended sequence
        push(8'hF0); push(8'h1C); push(8'hE0); push(8'hF0); push(8'h5A);
        step();
        chk("seq_irq", {15'h0, bus.irq}, 16'h0001);
        peek(16'h0060, v); chk("seq_head0", v, 16'h009E);
        rd(16'h0060);
        peek(16'h0060, v); chk("seq_head1", v, 16'h00E0);
        rd(16'h0060);
        peek(16'h0060, v); chk("seq_head2", v, 16'h009C);
        rd(16'h0060);
        peek(16'h0060, v); chk("seq_empty", v, 16'h0000);
        step();
        chk("seq_irq_off", {15'h0, bus.irq}, 16'h0000);

        // overflow with 17 pushes
        for (int i = 0; i < 17; i++) push(8'h1C);
        peek(16'h0064, v); chk("ovf_stat", v, 16'h000F);
        rd(16'h0064);
        peek(16'h0064, v); chk("ovf_cleared", v, 16'h000D);

        // push and pop together while full
        bus.port_addr = 16'h0060;
        bus.port_read = 1'b1;
        step();
        bus.port_read = 1'b0;
        bus.ps2_data = 8'h29;
        bus.ps2_data_clk = 1'b1;
        step();
        bus.ps2_data_clk = 1'b0;
        peek(16'h0064, v); chk("full_pp_stat", v, 16'h000D);
        for (int i = 0; i < 15; i++) rd(16'h0060);
        peek(16'h0060, v); chk("full_pp_tail", v, 16'h0039);
        rd(16'h0060);
        peek(16'h0064, v); chk("full_pp_empty", v, 16'h0004);

        // flush, irq disable
        for (int i = 0; i < 5; i++) push(8'h1C);
        wr(16'h0064, 16'h0001);
        step();
        chk("flush_irq", {15'h0, bus.irq}, 16'h0000);
        peek(16'h0064, v); chk("flush_stat", v, 16'h0000);
        wr(16'h0064, 16'h0000);
        push(8'h29);
        step(); step();
        chk("irqdis_irq", {15'h0, bus.irq}, 16'h0000);
        peek(16'h0060, v); chk("irqdis_head", v, 16'h0039);
        wr(16'h0064, 16'h0002);
        rd(16'h0060);

        // reset discards pending break
        push(8'hF0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        push(8'h1C);
        peek(16'h0060, v); chk("rst_brk_head", v, 16'h001E);
        rd(16'h0060);

        // randomised traffic
        for (int n = 0; n < 4000; n++) begin
            int k;
            rst_n = ($urandom_range(0, 299) != 0);
            k = $urandom_range(0, 9);
            bus.port_addr = (k < 5) ? 16'h0060 : (k < 8) ? 16'h0064 : 16'($urandom);
            bus.port_read = ($urandom_range(0, 2) == 0);
            bus.port_clk = ($urandom_range(0, 19) == 0);
            bus.port_out = 16'($urandom);
            bus.port_out[0] = ($urandom_range(0, 3) == 0);
            bus.port_out[1] = ($urandom_range(0, 3) != 0);
            bus.port_bit = 1'($urandom);
            bus.ps2_data_clk = (n < 2000) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
            k = $urandom_range(0, 9);
            bus.ps2_data = (k < 2) ? 8'hF0 : (k == 2) ? 8'hE0 : 8'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/kbd_port_controller.md
KBD_PORT_CONTROLLER -- requirements
Module: kbd_port_controller

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, scancode FIFO entries; power of two, range 2..256.
REQ-002 SHALL have parameter DATA_PORT, default 16'h0060, keyboard data port address.
REQ-003 SHALL have parameter STAT_PORT, default 16'h0064, keyboard status/command port address.
REQ-004 SHALL have port clock50  in  1  system clock; the only clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port port_addr  in  16  I/O port address.
REQ-007 SHALL have port port_in  out  16  read data to CPU.
REQ-008 SHALL have port port_out  in  16  write data from CPU.
REQ-009 SHALL have port port_bit  in  1  access width (0=byte, 1=word); accepted, no effect.
REQ-010 SHALL have port port_clk  in  1  write strobe, high one cycle per write.
REQ-011 SHALL have port port_read  in  1  read strobe; a read completes on its falling edge.
REQ-012 SHALL have port ps2_data  in  8  received PS/2 set-2 byte.
REQ-013 SHALL have port ps2_data_clk  in  1  one-cycle strobe, ps2_data valid.
REQ-014 SHALL have port irq  out  1  level interrupt request (IRQ1).

Function
REQ-015 port_in SHALL be combinational: DATA_PORT -> {8'h00, FIFO head} (8'h00 when empty); STAT_PORT -> {8'h00, status}; any other address -> 16'h0000.
REQ-016 Status byte SHALL be: bit0 = FIFO not empty, bit1 = overflow sticky, bit2 = irq_en, bit3 = FIFO full, bits 7:4 = 0.
REQ-017 A read is detected when port_read was 1 last cycle and is 0 now (registered previous value).
REQ-018 Completed read at DATA_PORT with FIFO not empty SHALL pop one entry; when empty, no pop.
REQ-019 Completed read at STAT_PORT SHALL clear the overflow sticky in the same cycle.
REQ-020 port_clk=1 at STAT_PORT SHALL act as a command: port_out[0]=1 flushes the FIFO; port_out[1] is loaded into irq_en.
REQ-021 port_clk at any other address SHALL be ignored.
REQ-022 ps2_data_clk with byte 8'hF0 SHALL set the break flag and push nothing.
REQ-023 ps2_data_clk with byte 8'hE0 SHALL push 8'hE0 unchanged and leave the break flag unchanged.
REQ-024 Any other byte SHALL be translated set-2 -> set-1 (unlisted codes pass through); push {brk, xt[6:0]} when the break flag is set, else xt; then clear the break flag.
REQ-025 Push latency SHALL be 1 cycle: entry visible at port_in/status the cycle after ps2_data_clk.
REQ-026 Push to a full FIFO SHALL drop the byte and set overflow; the break flag still clears.
REQ-027 Simultaneous push and pop when full SHALL perform both, with no overflow; count unchanged.
REQ-028 Simultaneous push and pop when empty SHALL push only.
REQ-029 Flush coincident with push SHALL flush; the pushed byte is lost and overflow is unchanged.
REQ-030 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be $clog2(FIFO_DEPTH)+1 bits wide.
REQ-031 irq SHALL be registered: irq = irq_en AND FIFO not empty, one cycle after the state change.

Reset
REQ-032 With rst_n=0 at a clock edge: FIFO empty, pointers and count 0, break flag 0, overflow 0, irq_en 1, irq 0, read-edge register 0.
REQ-033 Reset mid-sequence (after F0, before the code) SHALL discard the pending break flag.
REQ-034 During reset, port_in SHALL show 16'h0000 at DATA_PORT and 16'h0004 at STAT_PORT (irq_en=1).

Structure
REQ-035 Package kbd_pkg SHALL hold default port addresses, constants SC_BREAK=8'hF0 and SC_EXT=8'hE0, and the set-2 -> set-1 translation function.
REQ-036 Sub-module kbd_fifo (sync FIFO, parametrised width/depth, push/pop/flush, empty/full/count) SHALL be the only child.

Verification
REQ-037 Push ps2 76, then read 60h -> port_in 16'h0001 before the read; status bit0 goes 1 -> 0 after the read.
REQ-038 Push F0,1C then E0,F0,5A -> FIFO contains 9E, E0, 9C in order; irq=1 until the third pop.
REQ-039 Push 17 bytes with FIFO_DEPTH=16 -> 16 entries, status 8'h0F; status read clears bit1 -> 8'h0D.
REQ-040 With FIFO full, push and pop in the same cycle -> count stays 16, overflow stays 0, new byte is the tail.
REQ-041 Write 64h with 16'h0001 while 5 entries are queued -> empty, irq 0; write 16'h0000 then push 29 -> irq stays 0, port_in at 60h 16'h0039.
REQ-042 Push F0, assert rst_n=0 for one cycle, then push 1C -> entry 8'h1E (no break bit).
